keys_debounced_pio: RTL and testbench
=====================================

# keys_debounced_pio

Parametrised successor to the two-key input port on the MP3 player SoC's Avalon-MM fabric. The block synchronises and debounces up to 32 push-button/switch inputs and captures edges in a write-1-to-clear register. It raises a maskable level interrupt, so software no longer polls raw, bouncing key levels. It sits as an Avalon-MM slave between the board key pins and the Nios II interconnect.

## Interface
Parameters:
- WIDTH, 2, number of input bits (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new level (≥2)
- EDGE_TYPE, 1, edge capture mode: 0 rising, 1 falling (active-low keys), 2 both

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- address  in  2  Avalon word address
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- readdata  out  32  registered Avalon read data
- in_port  in  WIDTH  asynchronous key inputs
- irq  out  1  level interrupt to the CPU

## Operation
- Register map (word offsets):
  - 0 DATA: debounced level, read-only.
  - 1 RAW: synchronised undebounced level, read-only.
  - 2 IRQMASK: read/write, bits [WIDTH-1:0].
  - 3 EDGECAP: read; write-1-to-clear.
- Unused upper bits read 0. Writes to offsets 0/1 are ignored.
- Synchroniser: two flops per bit (sync1, sync2), reset value 0.
- Debounce, per bit, with counter cnt of width clog2(DEBOUNCE_CYCLES) and accepted level stable:
  - sync2 == stable: cnt <= 0.
  - sync2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and is never accepted.
- Edge detect: a bit's edge event fires on the clock edge where stable changes, qualified by EDGE_TYPE (0: 0→1; 1: 1→0; 2: either).
- EDGECAP bit is set by an edge event and cleared by a write to offset 3 with writedata bit = 1. If set and clear occur in the same cycle, set wins.
- irq = |(EDGECAP & IRQMASK). It is combinational from registers with no added latency and stays high until software clears or masks it.
- Reset (any cycle, including mid-debounce):
  - sync1, sync2, stable, cnt, IRQMASK, EDGECAP and readdata go to 0.
  - irq goes low.
  - No edge event is generated by reset itself.

## Timing
- Read latency is 1 cycle: readdata is updated every cycle from address, whether or not a read is requested, exactly like the previous key port. It is valid the cycle after address is presented.
- Writes take effect at the clock edge where write is high. A read of the same register in the next cycle returns the new value.
- Input-to-DATA latency:
  - in_port changes before edge k.
  - sync2 shows the change after edge k+1.
  - stable updates at edge k+1+DEBOUNCE_CYCLES.
  - DATA read data is visible one edge later.
- EDGECAP and irq update on the same edge as stable.

## Structure
- Shared package keys_pio_pkg holds:
  - register offset constants DATA/RAW/IRQMASK/EDGECAP = 0..3
  - EDGE_RISING/EDGE_FALLING/EDGE_BOTH constants
- One sub-module, key_debounce: a single bit containing the synchroniser, counter and stable register, with outputs stable, rise and fall. Instantiate it WIDTH times in a generate loop. The top level holds the register file, edge selection, read mux and irq.

## Test plan
Benches use WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1 unless stated.
- Reset: in_port=4'hF held through reset → after reset, all registers read 0 and irq=0. DATA reads 4'hF only after 2+4 cycles, and EDGECAP stays 0 (rising edges are not captured).
- Bounce rejection: in_port[0] toggles every 2 cycles for 20 cycles, then settles at 1 → DATA[0] changes exactly once, 4 cycles after sync2 settles. Glitches of 3 cycles are never accepted.
- Falling capture plus irq: IRQMASK=4'b0010; drive in_port[1] 1→0 and hold → EDGECAP=4'b0010 and irq=1 on the same edge that DATA[1]=0. Write 0x2 to offset 3 → EDGECAP=0 and irq=0 on the next cycle.
- Set/clear collision: issue the W1C write to bit 2 on the exact cycle a new falling edge on bit 2 is accepted → EDGECAP[2] remains 1.
- Mask gating: EDGECAP=4'b1000 with IRQMASK=0 → irq=0. Write IRQMASK=4'h8 → irq=1 next cycle. Reading offset 2 returns 32'h8 and offset 1 returns the raw sync value.
- EDGE_TYPE=2, reset mid-count: a 1→0→1 sequence sets the bit once per accepted transition. Asserting reset at cnt=2 → cnt restarts and no edge is captured.

Source files
------------

// File: rtl/keys_pio_pkg.sv
// Shared definitions for the debounced key PIO: register offsets and edge-capture modes.
package keys_pio_pkg;

    typedef enum logic [1:0] {
        DATA    = 2'd0,
        RAW     = 2'd1,
        IRQMASK = 2'd2,
        EDGECAP = 2'd3
    } reg_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_BOTH    = 2;

    // Any mode value other than rising/falling behaves as both edges.
    function automatic logic [31:0] selectEdges(input int edgeType,
                                                input logic [31:0] rise,
                                                input logic [31:0] fall);
        logic [31:0] events;
        case (edgeType)
            EDGE_RISING:  events = rise;
            EDGE_FALLING: events = fall;
            default:      events = rise | fall;
        endcase
        return events;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key bit: two-flop synchroniser followed by a stable-count debouncer.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    output logic sync_o,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          accept;

    // Any sample matching the accepted level restarts the count, so short glitches never land.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_MAX) begin
            accept   = 1'b1;
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= in_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Edge pulses are asserted in the cycle before stable flips, so captures land on the same edge.
    assign rise_o   = accept & sync2_q;
    assign fall_o   = accept & ~sync2_q;
    assign sync_o   = sync2_q;
    assign stable_o = stable_q;

endmodule

// File: rtl/keys_debounced_pio.sv
// Avalon-MM slave exposing debounced keys, raw synchronised keys, an IRQ mask and W1C edge capture.
module keys_debounced_pio
    import keys_pio_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] rawLevel;
    logic [WIDTH-1:0] stableLevel;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edgeEvent;
    logic [WIDTH-1:0] edgeClear;
    logic [WIDTH-1:0] irqMask_q;
    logic [WIDTH-1:0] irqMask_d;
    logic [WIDTH-1:0] edgeCap_q;
    logic [WIDTH-1:0] edgeCap_d;
    logic [31:0]      readData_q;
    logic [31:0]      readData_d;
    logic             unusedWriteBits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk_i   (clk),
            .rst_i   (reset),
            .in_i    (in_port[i]),
            .sync_o  (rawLevel[i]),
            .stable_o(stableLevel[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    assign edgeEvent = WIDTH'(selectEdges(EDGE_TYPE, 32'(rise), 32'(fall)));

    // A capture in the same cycle as its W1C clear survives, so no edge is ever lost.
    always_comb begin
        irqMask_d = irqMask_q;
        edgeClear = '0;
        if (write && (address == IRQMASK)) begin
            irqMask_d = writedata[WIDTH-1:0];
        end
        if (write && (address == EDGECAP)) begin
            edgeClear = writedata[WIDTH-1:0];
        end
        edgeCap_d = (edgeCap_q & ~edgeClear) | edgeEvent;
    end

    always_comb begin
        readData_d = '0;
        case (address)
            DATA:    readData_d[WIDTH-1:0] = stableLevel;
            RAW:     readData_d[WIDTH-1:0] = rawLevel;
            IRQMASK: readData_d[WIDTH-1:0] = irqMask_q;
            EDGECAP: readData_d[WIDTH-1:0] = edgeCap_q;
            default: readData_d            = '0;
        endcase
    end

    // Read data is refreshed every cycle regardless of any read strobe, like the old key port.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqMask_q  <= '0;
            edgeCap_q  <= '0;
            readData_q <= '0;
        end else begin
            irqMask_q  <= irqMask_d;
            edgeCap_q  <= edgeCap_d;
            readData_q <= readData_d;
        end
    end

    assign readdata        = readData_q;
    assign irq             = |(edgeCap_q & irqMask_q);
    assign unusedWriteBits = ^writedata;

endmodule

// File: tb/tb_keys_debounced_pio.sv
// Directed bench for keys_debounced_pio: falling-edge instance plus a both-edge instance.
module tb_keys_debounced_pio;
    import keys_pio_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    logic        reset2;
    logic [1:0]  address2;
    logic        write2;
    logic [31:0] writedata2;
    logic [31:0] readdata2;
    logic [3:0]  in2;
    logic        irq2;

    int checks = 0;
    int errors = 0;

    keys_debounced_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
    );

    keys_debounced_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset(reset2), .address(address2), .write(write2),
        .writedata(writedata2), .readdata(readdata2), .in_port(in2), .irq(irq2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wrReg(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        write     = 1'b1;
        writedata = d;
        cyc(1);
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic rdReg(input logic [1:0] a, output logic [31:0] d);
        address = a;
        cyc(1);
        d = readdata;
    endtask

    logic [31:0] rd;
    logic        prev;
    int          changes;
    int          changeAt;
    logic        seen;

    initial begin
        reset = 1'b1; address = '0; write = 1'b0; writedata = '0; in_port = 4'hF;
        reset2 = 1'b1; address2 = 2'd3; write2 = 1'b0; writedata2 = '0; in2 = 4'h0;
        cyc(3);
        checkOutput("rst_readdata", readdata, 32'h0);
        checkOutput("rst_irq", {31'b0, irq}, 32'h0);
        checkOutput("rst_readdata2", readdata2, 32'h0);

        // Keys held high through reset: DATA follows only after sync + debounce delay.
        reset = 1'b0; reset2 = 1'b0; address = 2'd2;
        cyc(1); checkOutput("rst_irqmask", readdata, 32'h0); address = 2'd3;
        cyc(1); checkOutput("rst_edgecap", readdata, 32'h0); address = 2'd0;
        cyc(1); checkOutput("rst_data", readdata, 32'h0); address = 2'd1;
        cyc(1); checkOutput("rst_raw_synced", readdata, 32'hF); address = 2'd0;
        cyc(1); checkOutput("data_n5", readdata, 32'h0);
        cyc(1); checkOutput("data_n6", readdata, 32'h0);
        cyc(1); checkOutput("data_n7", readdata, 32'hF);
        rdReg(2'd3, rd); checkOutput("no_rise_capture", rd, 32'h0);
        checkOutput("rst_irq_after", {31'b0, irq}, 32'h0);

        // Bit 0 falls once so the bounce test starts from a low accepted level.
        in_port = 4'hE;
        cyc(8);
        rdReg(2'd3, rd); checkOutput("fall_bit0_cap", rd, 32'h1);
        wrReg(2'd3, 32'hF);
        rdReg(2'd3, rd); checkOutput("w1c_all", rd, 32'h0);

        address = 2'd0;
        cyc(1);
        checkOutput("bounce_start", readdata, 32'hE);
        prev = readdata[0]; changes = 0; changeAt = -1;
        for (int i = 0; i < 10; i++) begin
            in_port[0] = (i % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                cyc(1);
                if (readdata[0] !== prev) begin changes++; prev = readdata[0]; end
            end
        end
        in_port[0] = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            cyc(1);
            if (readdata[0] !== prev) begin changes++; prev = readdata[0]; changeAt = t; end
        end
        checkOutput("bounce_changes", changes, 1);
        checkOutput("bounce_latency", changeAt, 7);
        rdReg(2'd3, rd); checkOutput("bounce_no_capture", rd, 32'h0);

        // A 3-cycle low glitch must never reach DATA nor EDGECAP.
        address = 2'd0; changes = 0; prev = 1'b1;
        in_port[0] = 1'b0;
        for (int t = 0; t < 15; t++) begin
            if (t == 3) in_port[0] = 1'b1;
            cyc(1);
            if (readdata[0] !== prev) begin changes++; prev = readdata[0]; end
        end
        checkOutput("glitch3_changes", changes, 0);
        rdReg(2'd3, rd); checkOutput("glitch3_no_capture", rd, 32'h0);

        wrReg(2'd2, 32'h2);
        in_port = 4'hD;
        cyc(5); checkOutput("irq_before_accept", {31'b0, irq}, 32'h0);
        cyc(1); checkOutput("irq_on_accept", {31'b0, irq}, 32'h1);
        rdReg(2'd3, rd); checkOutput("edgecap_bit1", rd, 32'h2);
        rdReg(2'd0, rd); checkOutput("data_bit1_low", rd, 32'hD);
        wrReg(2'd3, 32'h2);
        checkOutput("irq_after_w1c", {31'b0, irq}, 32'h0);
        rdReg(2'd3, rd); checkOutput("edgecap_cleared", rd, 32'h0);

        // W1C on bit 2 lands on the very edge its falling transition is accepted.
        in_port = 4'h9;
        cyc(5);
        wrReg(2'd3, 32'h4);
        rdReg(2'd3, rd); checkOutput("collision_set_wins", rd, 32'h4);
        checkOutput("collision_irq_masked", {31'b0, irq}, 32'h0);

        wrReg(2'd3, 32'hF);
        wrReg(2'd2, 32'h0);
        in_port = 4'h1;
        cyc(8);
        checkOutput("mask_gates_irq", {31'b0, irq}, 32'h0);
        rdReg(2'd3, rd); checkOutput("edgecap_bit3", rd, 32'h8);
        wrReg(2'd2, 32'h8);
        checkOutput("unmask_irq", {31'b0, irq}, 32'h1);
        rdReg(2'd2, rd); checkOutput("irqmask_read", rd, 32'h8);
        rdReg(2'd1, rd); checkOutput("raw_read", rd, 32'h1);
        wrReg(2'd2, 32'hFFFF_FFF8);
        rdReg(2'd2, rd); checkOutput("irqmask_upper_zero", rd, 32'h8);
        wrReg(2'd0, 32'hFFFF_FFFF);
        wrReg(2'd1, 32'hFFFF_FFFF);
        rdReg(2'd0, rd); checkOutput("data_write_ignored", rd, 32'h1);
        rdReg(2'd1, rd); checkOutput("raw_write_ignored", rd, 32'h1);

        // Both-edge instance: EDGECAP is permanently addressed on dut2.
        in2[0] = 1'b1;
        cyc(6); checkOutput("both_rise_early", readdata2, 32'h0);
        cyc(1); checkOutput("both_rise", readdata2, 32'h1);
        write2 = 1'b1; writedata2 = 32'h1; cyc(1); write2 = 1'b0; writedata2 = '0;
        cyc(1); checkOutput("both_clear1", readdata2, 32'h0);
        in2[0] = 1'b0;
        cyc(7); checkOutput("both_fall", readdata2, 32'h1);
        write2 = 1'b1; writedata2 = 32'h1; cyc(1); write2 = 1'b0; writedata2 = '0;
        cyc(1); checkOutput("both_clear2", readdata2, 32'h0);
        checkOutput("both_irq_masked", {31'b0, irq2}, 32'h0);

        in2[0] = 1'b1;
        cyc(4);
        reset2 = 1'b1;
        cyc(1);
        reset2 = 1'b0;
        checkOutput("midcount_reset_rd", readdata2, 32'h0);
        seen = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            cyc(1);
            if (readdata2 !== 32'h0) seen = 1'b1;
        end
        checkOutput("midcount_no_capture", {31'b0, seen}, 32'h0);
        cyc(1); checkOutput("restart_capture", readdata2, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
